fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/ready handshake, and latches it into an instruction register. It presents the `op`/`funct` fields to the control unit and takes `branch` back from it, plus `zero` from the ALU, to select the next PC when the instruction retires.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset; must be word aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request, asserted for every FETCH cycle.
- imem_addr  out  32  fetch address (`pc_fetch`); valid while imem_req=1.
- imem_rdata  in  32  instruction word; sampled only when imem_req=1 and imem_ready=1.
- imem_ready  in  1  memory has the data this cycle; ignored when imem_req=0.
- branch  in  1  from control unit, decoded from the current `instr`.
- zero  in  1  ALU zero flag for the current instruction.
- imm_ext  in  32  sign-extended immediate of the current instruction.
- stall  in  1  downstream hold; blocks retire.
- instr  out  32  instruction register.
- instr_valid  out  1  `instr` holds a fetched, unretired instruction.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc  out  32  address of `instr`.
- pc_plus4  out  32  pc + 4, combinational.
- retire_count  out  32  number of retired instructions.

## Operation
- Two states: FETCH, VALID.
- FETCH: imem_req=1, imem_addr=pc_fetch, instr_valid=0. If imem_ready=1, then: instr<=imem_rdata, pc<=pc_fetch, next state VALID. Otherwise stay in FETCH with the address held stable.
- VALID: imem_req=0, instr_valid=1. Retire = instr_valid & ~stall.
  - On retire, the next PC is `pc_plus4 + {imm_ext[29:0],2'b00}` if branch&zero, else `pc_plus4`.
  - Also on retire: pc_fetch<=next PC, retire_count<=retire_count+1, next state FETCH.
  - If stall=1: hold instr, pc and state.
- branch, zero and imm_ext are sampled only on the retire cycle. They are don't-care otherwise.
- All PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000. retire_count wraps 0xFFFF_FFFF -> 0.
- imem_rdata/imem_ready are ignored in VALID state.
- Reset, including mid-FETCH while waiting on memory, gives:
  - state=FETCH, pc_fetch=RESET_PC, pc=RESET_PC, instr=0, instr_valid=0, retire_count=0.
  - A response arriving in the reset cycle is discarded.
- Reset values of outputs:
  - imem_req=1 (first cycle after reset is FETCH), imem_addr=RESET_PC.
  - instr=0, op=0, funct=0, instr_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4, retire_count=0.

## Timing
- The fetch is accepted in the same cycle that imem_ready=1. A zero-wait memory holds ready high in the first FETCH cycle.
- Fetch latency: instr_valid rises on the cycle after the accept edge. With zero wait states, the first reset-deasserted cycle is FETCH and instr_valid=1 in the following cycle.
- Each instruction takes at least 2 cycles (FETCH + VALID), plus one extra cycle per wait-state cycle and per stall cycle.
- Retire at cycle N puts imem_addr = next PC at cycle N+1.
- imem_req, imem_addr, instr_valid, instr, op, funct and pc are registered or state-decoded only, with no combinational path from inputs.
- pc_plus4 is combinational from pc.

## Test plan
- Reset, then zero-wait memory returning 0x0000_0020 (add, funct 0x20) -> imem_addr=0x0 in cycle 0; instr_valid=1, op=0, funct=0x20, pc=0 in cycle 1.
- imem_ready low for 3 cycles -> imem_addr stays 0x4 and instr_valid stays 0 for 3 cycles; instr loads on the 4th cycle.
- Branch taken: pc=0x10, branch=1, zero=1, imm_ext=0xFFFF_FFFE -> next imem_addr=0x0C, retire_count+1.
- Branch not taken: pc=0x10, branch=1, zero=0 -> next imem_addr=0x14.
- Stall=1 for 2 cycles in VALID -> instr/pc held, imem_req=0, retire_count unchanged; fetch of pc+4 starts the cycle after stall drops.
- Wrap and reset:
  - pc=0xFFFF_FFFC retires, not taken -> imem_addr=0x0.
  - Reset asserted mid-wait at imem_addr=0x40 -> next cycle imem_addr=RESET_PC, instr_valid=0, retire_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over a
// request/ready handshake and retires it into the next-PC selection.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_count
);

    typedef enum logic {FETCH, VALID} state_t;

    state_t      state;
    logic [31:0] pc_fetch;
    logic [31:0] next_pc;
    logic        retire;

    // Branch target is word-scaled; the left shift drops imm_ext[31:30] by design.
    function automatic logic [31:0] select_next_pc(input logic [31:0] seq_pc,
                                                   input logic [31:0] imm,
                                                   input logic        taken);
        select_next_pc = taken ? (seq_pc + (imm << 2)) : seq_pc;
    endfunction

    assign imem_addr = pc_fetch;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign retire    = (state == VALID) && !stall;
    assign next_pc   = select_next_pc(pc_plus4, imm_ext, branch & zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            pc_fetch     <= RESET_PC;
            pc           <= RESET_PC;
            instr        <= 32'd0;
            imem_req     <= 1'b1;
            instr_valid  <= 1'b0;
            retire_count <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        pc          <= pc_fetch;
                        state       <= VALID;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (retire) begin
                        pc_fetch     <= next_pc;
                        retire_count <= retire_count + 32'd1;
                        state        <= FETCH;
                        imem_req     <= 1'b1;
                        instr_valid  <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
